// File: rtl/spi_cmd_pkg.sv
// spi_cmd_ctrl shared definitions: opcodes, frame lengths, FSM states.
// Optional feature macro: SPI_CMD_AUTOINC_EN (see spi_cmd_ctrl.sv).
package spi_cmd_pkg;

    localparam logic [2:0] OP_WRITE_AT   = 3'b000;
    localparam logic [2:0] OP_READ_AT    = 3'b001;
    localparam logic [2:0] OP_WRITE_NEXT = 3'b010;
    localparam logic [2:0] OP_READ_NEXT  = 3'b011;

    localparam logic [2:0] LEN_WRITE_AT   = 3'd4;
    localparam logic [2:0] LEN_READ_AT    = 3'd3;
    localparam logic [2:0] LEN_WRITE_NEXT = 3'd2;
    localparam logic [2:0] LEN_READ_NEXT  = 3'd1;
    localparam logic [2:0] LEN_ILLEGAL    = 3'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_DECODE,
        S_REQ,
        S_WAIT_CS
    } state_e;

    // Frame length is independent of the autoincrement build option
    function automatic logic [2:0] op_length(input logic [2:0] op);
        case (op)
            OP_WRITE_AT:   op_length = LEN_WRITE_AT;
            OP_READ_AT:    op_length = LEN_READ_AT;
            OP_WRITE_NEXT: op_length = LEN_WRITE_NEXT;
            OP_READ_NEXT:  op_length = LEN_READ_NEXT;
            default:       op_length = LEN_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/spi_cmd_ctrl_sync2.sv
// sync2: multi-flop level synchronizer with a configurable reset value.
// Used for the spi_cs_n and spi_done crossings into sys_clk.
module sync2 #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff_q;
    logic [STAGES-1:0] ff_d;

    // Shift the async input one stage per clock
    always_comb begin
        ff_d = {ff_q[STAGES-2:0], d};
    end

    // Synchronizer chain, reset to the inactive level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff_q <= {STAGES{RST_VAL}};
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[STAGES-1];

endmodule

// File: rtl/spi_cmd_ctrl.sv
// spi_cmd_ctrl: latches a completed SPI command frame and runs one bus op.
// Define SPI_CMD_AUTOINC_EN to enable WRITE_NEXT / READ_NEXT streaming.
module spi_cmd_ctrl
    import spi_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH  = 17,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_reset_n,
    input  logic                  spi_cs_n,
    input  logic                  spi_done,
    input  logic [3:0][7:0]       rx,
    output logic [2:0]            length,
    output logic                  bus_req,
    input  logic                  bus_ack,
    output logic                  bus_we,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [7:0]            bus_wr_data,
    input  logic [7:0]            bus_rd_data,
    output logic [7:0]            spi_tx_data,
    output logic                  busy
);

    state_e                  state_q, state_d;
    logic [3:0][7:0]         rx_q, rx_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    we_q, we_d;
    logic [7:0]              wr_q, wr_d;
    logic [7:0]              tx_q, tx_d;
    logic                    done_prev_q, done_prev_d;
    logic                    cs_s;
    logic                    done_s;
    logic [16:0]             addr_at_w;
    logic [16:0]             addr_at_r;
    logic                    unused_bits;

    sync2 #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .clk   (sys_clk),
        .rst_n (sys_reset_n),
        .d     (spi_cs_n),
        .q     (cs_s)
    );

    sync2 #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_done_sync (
        .clk   (sys_clk),
        .rst_n (sys_reset_n),
        .d     (spi_done),
        .q     (done_s)
    );

    assign length      = op_length(rx[0][7:5]);
    assign addr_at_w   = {rx_q[0][0], rx_q[2], rx_q[3]};
    assign addr_at_r   = {rx_q[0][0], rx_q[1], rx_q[2]};
    assign unused_bits = ^rx_q[0][4:1];

    // Sequencer: frame latch, decode, one bus op, wait for cs_n release
    always_comb begin
        state_d     = state_q;
        rx_d        = rx_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wr_d        = wr_q;
        tx_d        = tx_q;
        done_prev_d = done_s;
        unique case (state_q)
            S_IDLE: begin
                if (done_s && !done_prev_q && !cs_s) begin
                    state_d = S_LATCH;
                end
            end
            S_LATCH: begin
                rx_d    = rx;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = S_WAIT_CS;
                case (rx_q[0][7:5])
                    OP_WRITE_AT: begin
                        addr_d  = ADDR_WIDTH'(addr_at_w);
                        we_d    = 1'b1;
                        wr_d    = rx_q[1];
                        state_d = S_REQ;
                    end
                    OP_READ_AT: begin
                        addr_d  = ADDR_WIDTH'(addr_at_r);
                        we_d    = 1'b0;
                        state_d = S_REQ;
                    end
`ifdef SPI_CMD_AUTOINC_EN
                    OP_WRITE_NEXT: begin
                        we_d    = 1'b1;
                        wr_d    = rx_q[1];
                        state_d = S_REQ;
                    end
                    OP_READ_NEXT: begin
                        we_d    = 1'b0;
                        state_d = S_REQ;
                    end
`endif
                    default: begin
                        state_d = S_WAIT_CS;
                    end
                endcase
            end
            S_REQ: begin
                if (bus_ack) begin
                    if (!we_q) begin
                        tx_d = bus_rd_data;
                    end
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    state_d = S_WAIT_CS;
                end
            end
            S_WAIT_CS: begin
                if (cs_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            state_q     <= S_IDLE;
            rx_q        <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wr_q        <= 8'h00;
            tx_q        <= 8'h00;
            done_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rx_q        <= rx_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wr_q        <= wr_d;
            tx_q        <= tx_d;
            done_prev_q <= done_prev_d;
        end
    end

    assign bus_req     = (state_q == S_REQ);
    assign bus_we      = we_q;
    assign bus_addr    = addr_q;
    assign bus_wr_data = wr_q;
    assign spi_tx_data = tx_q;
    assign busy        = (state_q == S_LATCH) || (state_q == S_DECODE) ||
                         (state_q == S_REQ);

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// tb_spi_cmd_ctrl: randomized frames checked against a frame-level model.
// Follows SPI_CMD_AUTOINC_EN when the bench is built with it.
module tb_spi_cmd_ctrl;

    logic            sys_clk = 1'b0;
    logic            sys_reset_n = 1'b0;
    logic            spi_cs_n = 1'b1;
    logic            spi_done = 1'b0;
    logic [3:0][7:0] rx = '0;
    logic [2:0]      length;
    logic            bus_req;
    logic            bus_ack = 1'b0;
    logic            bus_we;
    logic [16:0]     bus_addr;
    logic [7:0]      bus_wr_data;
    logic [7:0]      bus_rd_data = 8'h00;
    logic [7:0]      spi_tx_data;
    logic            busy;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [16:0] m_addr = 17'h0;
    logic [7:0]  m_tx = 8'h00;

    always #5 sys_clk = ~sys_clk;

    spi_cmd_ctrl #(.ADDR_WIDTH(17), .SYNC_STAGES(2)) dut (
        .sys_clk     (sys_clk),
        .sys_reset_n (sys_reset_n),
        .spi_cs_n    (spi_cs_n),
        .spi_done    (spi_done),
        .rx          (rx),
        .length      (length),
        .bus_req     (bus_req),
        .bus_ack     (bus_ack),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wr_data (bus_wr_data),
        .bus_rd_data (bus_rd_data),
        .spi_tx_data (spi_tx_data),
        .busy        (busy)
    );

    // One complete SPI frame, then cs_n release; checks against the model
    task automatic run_frame(input logic [7:0] c, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] b3,
                             input logic [7:0] rd, input bit rise_in_req,
                             input string nm);
        logic [2:0]  op;
        logic [2:0]  e_len;
        bit          e_op;
        logic        e_we;
        logic [16:0] e_addr;
        logic [7:0]  e_data;
        bit          got;
        int          hold;
        bit          autoinc;
`ifdef SPI_CMD_AUTOINC_EN
        autoinc = 1'b1;
`else
        autoinc = 1'b0;
`endif
        op     = c[7:5];
        e_op   = 1'b0;
        e_we   = 1'b0;
        e_addr = m_addr;
        e_data = 8'h00;
        if (op == 3'd0) e_len = 3'd4;
        else if (op == 3'd1) e_len = 3'd3;
        else if (op == 3'd2) e_len = 3'd2;
        else e_len = 3'd1;
        if (op == 3'd0) begin
            e_op = 1'b1; e_we = 1'b1;
            e_addr = {c[0], b2, b3}; e_data = b1;
        end else if (op == 3'd1) begin
            e_op = 1'b1; e_addr = {c[0], b1, b2};
        end else if (op == 3'd2) begin
            e_op = autoinc; e_we = 1'b1; e_data = b1;
        end else if (op == 3'd3) begin
            e_op = autoinc;
        end
        spi_cs_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        rx = {b3, b2, b1, c};
        @(negedge sys_clk);
        n_cmp++;
        if (length !== e_len)
            $display("FAIL %s length: got %0d want %0d", nm, length, e_len);
        if (length !== e_len) n_bad++;
        spi_done = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge sys_clk);
            if (bus_req === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (got !== e_op) begin
            n_bad++;
            $display("FAIL %s bus_req seen: got %0b want %0b", nm, got, e_op);
        end
        if (got && e_op) begin
            n_cmp++;
            if ({busy, bus_we, bus_addr, e_we ? bus_wr_data : 8'h00} !==
                {1'b1, e_we, e_addr, e_data}) begin
                n_bad++;
                $display("FAIL %s req fields: got we=%0b a=%h d=%h want we=%0b a=%h d=%h",
                         nm, bus_we, bus_addr, bus_wr_data, e_we, e_addr, e_data);
            end
            if (rise_in_req) begin
                spi_cs_n = 1'b1;
                spi_done = 1'b0;
            end
            hold = $urandom_range(0, 3);
            for (int k = 0; k < hold; k++) begin
                @(negedge sys_clk);
                n_cmp++;
                if ({bus_req, bus_we, bus_addr, e_we ? bus_wr_data : 8'h00} !==
                    {1'b1, e_we, e_addr, e_data}) begin
                    n_bad++;
                    $display("FAIL %s hold: got req=%0b a=%h want req=1 a=%h",
                             nm, bus_req, bus_addr, e_addr);
                end
            end
            bus_ack = 1'b1;
            bus_rd_data = rd;
            @(negedge sys_clk);
            bus_ack = 1'b0;
            m_addr = e_addr + 17'd1;
            if (!e_we) m_tx = rd;
            n_cmp++;
            if ({bus_req, busy, spi_tx_data} !== {1'b0, 1'b0, m_tx}) begin
                n_bad++;
                $display("FAIL %s after ack: got req=%0b busy=%0b tx=%h want 0 0 %h",
                         nm, bus_req, busy, spi_tx_data, m_tx);
            end
        end
        spi_cs_n = 1'b1;
        spi_done = 1'b0;
        repeat (6) @(negedge sys_clk);
        n_cmp++;
        if ({busy, bus_req, spi_tx_data} !== {1'b0, 1'b0, m_tx}) begin
            n_bad++;
            $display("FAIL %s idle: got busy=%0b req=%0b tx=%h want 0 0 %h",
                     nm, busy, bus_req, spi_tx_data, m_tx);
        end
    endtask

    task automatic test_reset();
        sys_reset_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        n_cmp++;
        if ({bus_req, bus_we, bus_addr, bus_wr_data, spi_tx_data, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset outputs: got req=%0b we=%0b a=%h d=%h tx=%h busy=%0b want all 0",
                     bus_req, bus_we, bus_addr, bus_wr_data, spi_tx_data, busy);
        end
        sys_reset_n = 1'b1;
        m_addr = 17'h0;
        m_tx = 8'h00;
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic test_write_at();
        run_frame(8'h01, 8'hA5, 8'h80, 8'h00, 8'h00, 1'b0, "write_at");
    endtask

    task automatic test_read_at();
        run_frame(8'h20, 8'h12, 8'h34, 8'hEE, 8'h5A, 1'b0, "read_at");
    endtask

    task automatic test_autoinc_wrap();
        run_frame(8'h01, 8'h3C, 8'hFF, 8'hFF, 8'h00, 1'b0, "wr_1ffff");
        run_frame(8'h40, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0, "write_next");
    endtask

    task automatic test_read_next();
        run_frame(8'h60, 8'h00, 8'h00, 8'h00, 8'hC3, 1'b0, "read_next");
    endtask

    task automatic test_short_frame();
        bit got;
        spi_cs_n = 1'b0;
        rx = {8'h00, 8'h00, 8'hB7, 8'h01};
        repeat (3) @(negedge sys_clk);
        spi_cs_n = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge sys_clk);
            if (bus_req === 1'b1 || busy === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (got !== 1'b0) begin
            n_bad++;
            $display("FAIL short_frame activity: got %0b want 0", got);
        end
        run_frame(8'h00, 8'h9D, 8'h04, 8'h56, 8'h00, 1'b0, "after_short");
    endtask

    task automatic test_reset_mid_req();
        bit got;
        spi_cs_n = 1'b0;
        repeat (2) @(negedge sys_clk);
        rx = {8'h00, 8'h78, 8'h56, 8'h21};
        @(negedge sys_clk);
        spi_done = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge sys_clk);
            if (bus_req === 1'b1) got = 1'b1;
        end
        n_cmp++;
        if (got !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_req req seen: got 0 want 1");
        end
        sys_reset_n = 1'b0;
        @(negedge sys_clk);
        n_cmp++;
        if ({bus_req, bus_we, bus_addr, bus_wr_data, spi_tx_data, busy} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_req outputs: got req=%0b we=%0b a=%h d=%h tx=%h busy=%0b want all 0",
                     bus_req, bus_we, bus_addr, bus_wr_data, spi_tx_data, busy);
        end
        spi_cs_n = 1'b1;
        spi_done = 1'b0;
        repeat (2) @(negedge sys_clk);
        sys_reset_n = 1'b1;
        m_addr = 17'h0;
        m_tx = 8'h00;
        repeat (4) @(negedge sys_clk);
        run_frame(8'h21, 8'h00, 8'h10, 8'h00, 8'h81, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        run_frame(8'h00, 8'h11, 8'h22, 8'h33, 8'h00, 1'b1, "cs_rise_wr");
        run_frame(8'h20, 8'h44, 8'h55, 8'h00, 8'h99, 1'b1, "cs_rise_rd");
        run_frame(8'h40, 8'h66, 8'h00, 8'h00, 8'h00, 1'b0, "next_wr");
        run_frame(8'h60, 8'h00, 8'h00, 8'h00, 8'h7E, 1'b0, "next_rd");
    endtask

    task automatic test_random();
        logic [7:0] c;
        for (int i = 0; i < 24; i++) begin
            c = 8'($urandom);
            run_frame(c, 8'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), ($urandom_range(0, 3) == 0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_write_at();
        test_read_at();
        test_autoinc_wrap();
        test_read_next();
        test_short_frame();
        test_back_to_back();
        test_reset_mid_req();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
